// File: rtl/xswitch_gen_pkg.sv
// xswitch_gen_pkg: shared types and width helpers for the xswitch_gen crossbar.
package xswitch_gen_pkg;

  // Widest beat fields the switch supports (N_PORTS up to 16, DATA_W up to 64).
  // The address field keeps one spare bit so that N_PORTS itself is representable.
  localparam int unsigned MAX_AW = 5;
  localparam int unsigned MAX_DW = 64;

  typedef logic [1:0] prio_t;

  // One queued beat: destination port and payload.
  typedef struct packed {
    logic [MAX_AW-1:0] addr;
    logic [MAX_DW-1:0] data;
  } beat_t;

  // Index width for n items, never less than one bit.
  function automatic int unsigned width_for(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xsw_fifo.sv
// xsw_fifo: synchronous FIFO with occupancy count and registered
// empty / full / almost-empty / almost-full flags. Head is read combinationally.
module xsw_fifo
  import xswitch_gen_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AE_LVL = 2,
  parameter int unsigned AF_LVL = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [width_for(DEPTH):0] count,
  output logic                     empty,
  output logic                     full,
  output logic                     ae,
  output logic                     af
);

  localparam int unsigned PW = width_for(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt_nxt;
  logic          do_push;
  logic          do_pop;

  // A push while full is discarded even if a pop frees a slot this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    cnt_nxt = count;
    case ({do_push, do_pop})
      2'b10:   cnt_nxt = count + 1'b1;
      2'b01:   cnt_nxt = count - 1'b1;
      default: cnt_nxt = count;
    endcase
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, count and flags; flags are registered from the next count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      ae     <= 1'b1;
      af     <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      full  <= (cnt_nxt == CW'(DEPTH));
      ae    <= (cnt_nxt <= CW'(AE_LVL));
      af    <= (cnt_nxt >= CW'(AF_LVL));
    end
  end

endmodule

// File: rtl/xswitch_gen.sv
// xswitch_gen: N-port crossbar packet switch. Per-input FIFOs, per-output
// priority + round-robin arbiter feeding a one-beat output register.
// Optional macro XSWITCH_GEN_DROP_CNT_EN adds per-input saturating drop counters.
module xswitch_gen
  import xswitch_gen_pkg::*;
#(
  parameter int unsigned N_PORTS    = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AE_LVL     = 2,
  parameter int unsigned AF_LVL     = 6
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [N_PORTS*DATA_W-1:0]            data_in,
  input  logic [N_PORTS*width_for(N_PORTS)-1:0] addr_in,
  input  logic [N_PORTS-1:0]                   wr_en,
  output logic [N_PORTS-1:0]                   data_rcv,
  output logic [N_PORTS-1:0]                   fifo_empty,
  output logic [N_PORTS-1:0]                   fifo_full,
  output logic [N_PORTS-1:0]                   fifo_ae,
  output logic [N_PORTS-1:0]                   fifo_af,
  output logic [N_PORTS*DATA_W-1:0]            data_out,
  output logic [N_PORTS*width_for(N_PORTS)-1:0] addr_out,
  output logic [N_PORTS-1:0]                   data_rdy,
  input  logic [N_PORTS-1:0]                   rd_en,
  input  logic [1:0]                           prio_val,
  input  logic                                 prio_wr,
  input  logic                                 port_en,
  input  logic                                 port_wr,
  input  logic [width_for(N_PORTS)-1:0]        port_sel
`ifdef XSWITCH_GEN_DROP_CNT_EN
  ,
  output logic [N_PORTS*8-1:0]                 drop_cnt
`endif
);

  localparam int unsigned AW = width_for(N_PORTS);
  localparam int unsigned BW = AW + DATA_W;
  localparam int unsigned CW = width_for(FIFO_DEPTH) + 1;

  prio_t                      prio [N_PORTS];
  logic [N_PORTS-1:0]         en;
  logic [N_PORTS-1:0]         push;
  logic [N_PORTS-1:0]         pop;
  logic [N_PORTS-1:0]         head_bad;
  logic [N_PORTS-1:0]         wr_drop;
  beat_t                      head [N_PORTS];
  logic [N_PORTS*N_PORTS-1:0] gnt_flat;

  // Configuration registers: priority and enable per port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned p = 0; p < N_PORTS; p++) prio[p] <= '0;
      en <= '1;
    end else begin
      if (prio_wr && (MAX_AW'(port_sel) < MAX_AW'(N_PORTS))) prio[port_sel] <= prio_val;
      if (port_wr && (MAX_AW'(port_sel) < MAX_AW'(N_PORTS))) en[port_sel] <= port_en;
    end
  end

  // Input side: one FIFO per port plus head decode.
  for (genvar p = 0; p < N_PORTS; p++) begin : g_in
    logic [BW-1:0] dout;
    logic [CW-1:0] count;
    logic          unused_in;

    assign push[p]    = wr_en[p] & en[p] & ~fifo_full[p];
    assign wr_drop[p] = wr_en[p] & ~push[p];

    xsw_fifo #(
      .W      (BW),
      .DEPTH  (FIFO_DEPTH),
      .AE_LVL (AE_LVL),
      .AF_LVL (AF_LVL)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[p]),
      .pop   (pop[p]),
      .din   ({addr_in[p*AW +: AW], data_in[p*DATA_W +: DATA_W]}),
      .dout  (dout),
      .count (count),
      .empty (fifo_empty[p]),
      .full  (fifo_full[p]),
      .ae    (fifo_ae[p]),
      .af    (fifo_af[p])
    );

    assign head[p] = {MAX_AW'(dout[BW-1 -: AW]), MAX_DW'(dout[DATA_W-1:0])};

    // Out-of-range heads are discarded; a disabled input keeps them frozen too.
    assign head_bad[p] = en[p] & ~fifo_empty[p] & (head[p].addr >= MAX_AW'(N_PORTS));

    assign unused_in = ^{count, head[p]};
  end

  // Pop each input that was granted by some output or holds a bad head.
  always_comb begin
    pop = head_bad;
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        if (gnt_flat[o*N_PORTS + i]) pop[i] = 1'b1;
      end
    end
  end

  // Output side: arbiter and one-beat register per output.
  for (genvar o = 0; o < N_PORTS; o++) begin : g_out
    logic [N_PORTS-1:0] cand;
    logic [N_PORTS-1:0] gnt;
    logic [AW-1:0]      last;
    logic [AW-1:0]      sel;
    logic               hit;
    logic               can_load;
    prio_t              best;
    int unsigned        idx;
    logic [DATA_W-1:0]  dq;
    logic [AW-1:0]      aq;
    logic               vq;

    // Highest priority wins; ties resolved round-robin starting after the last grant.
    always_comb begin
      cand = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        cand[i] = en[o] & en[i] & ~fifo_empty[i] & (head[i].addr == MAX_AW'(o));
      end
      best = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        if (cand[i] && (prio[i] > best)) best = prio[i];
      end
      hit = 1'b0;
      sel = '0;
      idx = 0;
      for (int unsigned k = 1; k <= N_PORTS; k++) begin
        idx = (int'(last) + k) % N_PORTS;
        if (!hit && cand[idx] && (prio[idx] == best)) begin
          hit = 1'b1;
          sel = AW'(idx);
        end
      end
      can_load = ~vq | rd_en[o];
      gnt = '0;
      if (hit && can_load) gnt[sel] = 1'b1;
    end

    assign gnt_flat[o*N_PORTS +: N_PORTS] = gnt;

    // Output register load on grant, clear on read; pointer moves only on a grant.
    always_ff @(posedge clk) begin
      if (reset) begin
        dq   <= '0;
        aq   <= '0;
        vq   <= 1'b0;
        last <= AW'(N_PORTS - 1);
      end else if (|gnt) begin
        dq   <= head[sel].data[DATA_W-1:0];
        aq   <= sel;
        vq   <= 1'b1;
        last <= sel;
      end else if (rd_en[o]) begin
        vq <= 1'b0;
      end
    end

    assign data_out[o*DATA_W +: DATA_W] = dq;
    assign addr_out[o*AW +: AW]         = aq;
    assign data_rdy[o]                  = vq;
  end

  // Acceptance pulse one cycle after a successful push.
  always_ff @(posedge clk) begin
    if (reset) data_rcv <= '0;
    else       data_rcv <= push;
  end

`ifdef XSWITCH_GEN_DROP_CNT_EN
  for (genvar p = 0; p < N_PORTS; p++) begin : g_drop
    logic [7:0] cnt;
    logic [8:0] sum;

    // A dropped write and a discarded head can land in the same cycle.
    assign sum = {1'b0, cnt} + {8'b0, wr_drop[p]} + {8'b0, head_bad[p]};

    // Saturating drop counter.
    always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else       cnt <= sum[8] ? 8'hFF : sum[7:0];
    end

    assign drop_cnt[p*8 +: 8] = cnt;
  end
`else
  logic unused_drop;
  assign unused_drop = ^wr_drop;
`endif

endmodule

// File: tb/tb_xswitch_gen.sv
// tb_xswitch_gen: table-driven single-beat checks, scoreboard-checked
// multi-cycle sequences for arbitration, flags, port disable and reset.
`timescale 1ns/1ps
module tb_xswitch_gen;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N*DW-1:0] data_in = '0;
  logic [N*AW-1:0] addr_in = '0;
  logic [N-1:0]    wr_en = '0;
  logic [N-1:0]    rd_en = '0;
  logic [N-1:0]    data_rcv, fifo_empty, fifo_full, fifo_ae, fifo_af, data_rdy;
  logic [N*DW-1:0] data_out;
  logic [N*AW-1:0] addr_out;
  logic [1:0]      prio_val = '0;
  logic            prio_wr = 1'b0;
  logic            port_en = 1'b1;
  logic            port_wr = 1'b0;
  logic [AW-1:0]   port_sel = '0;
`ifdef XSWITCH_GEN_DROP_CNT_EN
  logic [N*8-1:0]  drop_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] src;
  } exp_t;

  exp_t sb [N][$];

  always #5 clk = ~clk;

  xswitch_gen #(
    .N_PORTS    (N),
    .DATA_W     (DW),
    .FIFO_DEPTH (8),
    .AE_LVL     (2),
    .AF_LVL     (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .addr_in    (addr_in),
    .wr_en      (wr_en),
    .data_rcv   (data_rcv),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_ae    (fifo_ae),
    .fifo_af    (fifo_af),
    .data_out   (data_out),
    .addr_out   (addr_out),
    .data_rdy   (data_rdy),
    .rd_en      (rd_en),
    .prio_val   (prio_val),
    .prio_wr    (prio_wr),
    .port_en    (port_en),
    .port_wr    (port_wr),
    .port_sel   (port_sel)
`ifdef XSWITCH_GEN_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input int a, input logic [DW-1:0] d);
    wr_en[p] = 1'b1;
    addr_in[p*AW +: AW] = AW'(a);
    data_in[p*DW +: DW] = d;
  endtask

  task automatic expect_beat(input int o, input logic [DW-1:0] d, input int s);
    exp_t e;
    e.data = d;
    e.src  = AW'(s);
    sb[o].push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_en = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int o = 0; o < N; o++) sb[o].delete();
  endtask

  task automatic wait_drain(input int o, input int budget);
    int c;
    c = 0;
    while (sb[o].size() != 0 && c < budget) begin
      tick();
      c++;
    end
    check($sformatf("drain_out%0d_left", o), sb[o].size(), 0);
  endtask

  task automatic cfg_port(input int p, input logic v);
    port_sel = AW'(p);
    port_en  = v;
    port_wr  = 1'b1;
    tick();
    port_wr  = 1'b0;
  endtask

  task automatic cfg_prio(input int p, input logic [1:0] v);
    port_sel = AW'(p);
    prio_val = v;
    prio_wr  = 1'b1;
    tick();
    prio_wr  = 1'b0;
  endtask

  // Scoreboard monitor: every beat read by a consumer must match the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      for (int o = 0; o < N; o++) begin
        if (data_rdy[o] && rd_en[o]) begin
          exp_t e;
          if (sb[o].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_extra_out%0d: got data 0x%0h src %0d, expected no beat",
                     o, data_out[o*DW +: DW], addr_out[o*AW +: AW]);
          end else begin
            e = sb[o].pop_front();
            check($sformatf("sb_data_out%0d", o), data_out[o*DW +: DW], e.data);
            check($sformatf("sb_src_out%0d", o), addr_out[o*AW +: AW], e.src);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  typedef struct {
    int            src;
    int            dst;
    logic [DW-1:0] data;
    logic [N-1:0]  exp_rcv;
    logic [AW-1:0] exp_src;
  } vec_t;

  vec_t vt [6];

  initial begin
    vt[0] = '{0, 2, 8'h5A, 4'b0001, 2'd0};
    vt[1] = '{1, 3, 8'hA5, 4'b0010, 2'd1};
    vt[2] = '{2, 0, 8'h3C, 4'b0100, 2'd2};
    vt[3] = '{3, 1, 8'hC3, 4'b1000, 2'd3};
    vt[4] = '{3, 3, 8'hFF, 4'b1000, 2'd3};
    vt[5] = '{0, 0, 8'h81, 4'b0001, 2'd0};

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_empty", fifo_empty, 4'hF);
    check("rst_ae",    fifo_ae,    4'hF);
    check("rst_full",  fifo_full,  4'h0);
    check("rst_af",    fifo_af,    4'h0);
    check("rst_rdy",   data_rdy,   4'h0);
    check("rst_rcv",   data_rcv,   4'h0);
    check("rst_data",  data_out,   32'h0);
    check("rst_addr",  addr_out,   8'h0);

    // Single beats through an idle path: rcv one edge after the push, rdy one edge later
    rd_en = '1;
    for (int k = 0; k < 6; k++) begin
      tick();
      drive(vt[k].src, vt[k].dst, vt[k].data);
      expect_beat(vt[k].dst, vt[k].data, int'(vt[k].exp_src));
      tick();
      wr_en = '0;
      @(negedge clk);
      check($sformatf("tv%0d_rcv", k), data_rcv, vt[k].exp_rcv);
      check($sformatf("tv%0d_rdy_early", k), data_rdy[vt[k].dst], 1'b0);
      @(negedge clk);
      check($sformatf("tv%0d_rdy", k), data_rdy[vt[k].dst], 1'b1);
      check($sformatf("tv%0d_rcv_pulse", k), data_rcv, 4'h0);
    end
    tick();
    tick();

    // Contention, equal priority: in1 and in3 alternate on out0
    do_reset();
    rd_en = '0;
    for (int b = 0; b < 4; b++) begin
      drive(1, 0, DW'(8'h10 + b));
      drive(3, 0, DW'(8'h30 + b));
      expect_beat(0, DW'(8'h10 + b), 1);
      expect_beat(0, DW'(8'h30 + b), 3);
      tick();
    end
    wr_en = '0;
    tick();
    @(negedge clk);
    check("cont_held", data_rdy[0], 1'b1);
    rd_en[0] = 1'b1;
    wait_drain(0, 30);
    rd_en[0] = 1'b0;
    tick();

    // prio[3]=3: in3 served until empty, then in1
    cfg_prio(3, 2'd3);
    for (int b = 0; b < 3; b++) begin
      drive(1, 0, DW'(8'h14 + b));
      drive(3, 0, DW'(8'h34 + b));
      tick();
    end
    wr_en = '0;
    for (int b = 0; b < 3; b++) expect_beat(0, DW'(8'h34 + b), 3);
    for (int b = 0; b < 3; b++) expect_beat(0, DW'(8'h14 + b), 1);
    tick();
    rd_en[0] = 1'b1;
    wait_drain(0, 30);
    rd_en = '0;
    tick();

    // Fill in2 behind a held beat on out1; flags track occupancy
    drive(0, 1, 8'h77);
    expect_beat(1, 8'h77, 0);
    tick();
    wr_en = '0;
    tick();
    tick();
    for (int k = 1; k <= 8; k++) begin
      drive(2, 1, DW'(8'h80 + k - 1));
      expect_beat(1, DW'(8'h80 + k - 1), 2);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("fill%0d_full", k), fifo_full[2], (k == 8));
      check($sformatf("fill%0d_af", k),   fifo_af[2],   (k >= 6));
      check($sformatf("fill%0d_ae", k),   fifo_ae[2],   (k <= 2));
      check($sformatf("fill%0d_rcv", k),  data_rcv[2],  1'b1);
    end
    drive(2, 1, 8'h88);
    @(posedge clk);
    @(negedge clk);
    wr_en = '0;
    check("full_drop_rcv", data_rcv[2], 1'b0);
    check("full_stays",    fifo_full[2], 1'b1);
    rd_en[1] = 1'b1;
    wait_drain(1, 40);
    tick();
    tick();
    @(negedge clk);
    check("drain_empty", fifo_empty[2], 1'b1);
    check("drain_ae",    fifo_ae[2],    1'b1);
    check("drain_rdy",   data_rdy[1],   1'b0);
    rd_en = '0;
    tick();

    // Disable port 1: held beat readable, queued beat frozen, write to in1 dropped
    drive(0, 1, 8'h91);
    expect_beat(1, 8'h91, 0);
    tick();
    drive(0, 1, 8'h92);
    expect_beat(1, 8'h92, 0);
    tick();
    wr_en = '0;
    tick();
    cfg_port(1, 1'b0);
    drive(1, 0, 8'hEE);
    tick();
    wr_en = '0;
    @(negedge clk);
    check("dis_rcv",   data_rcv[1],   1'b0);
    check("dis_empty", fifo_empty[1], 1'b1);
    rd_en[1] = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("dis_no_grant", data_rdy[1],   1'b0);
    check("dis_frozen",   fifo_empty[0], 1'b0);
    check("dis_sb_held",  sb[1].size(),  1);
    tick();
    cfg_port(1, 1'b1);
    wait_drain(1, 20);
    rd_en = '0;
    tick();

    // Reset mid-stream: one beat held on out3, three queued; prio[2]=2 beforehand
    cfg_prio(2, 2'd2);
    drive(1, 3, 8'hA1);
    drive(2, 3, 8'hB1);
    tick();
    drive(1, 3, 8'hA2);
    drive(2, 3, 8'hB2);
    tick();
    wr_en = '0;
    tick();
    @(negedge clk);
    check("pre_rst_rdy", data_rdy[3], 1'b1);
    check("pre_rst_src", addr_out[3*AW +: AW], 2'd2);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_empty", fifo_empty, 4'hF);
    check("mid_rst_rdy",   data_rdy,   4'h0);
    check("mid_rst_rcv",   data_rcv,   4'h0);
    tick();
    // With priorities back to 0 the round-robin serves in1 first
    drive(1, 3, 8'hC1);
    drive(2, 3, 8'hD1);
    expect_beat(3, 8'hC1, 1);
    expect_beat(3, 8'hD1, 2);
    tick();
    wr_en = '0;
    tick();
    rd_en[3] = 1'b1;
    wait_drain(3, 20);
    rd_en = '0;
    tick();

`ifdef XSWITCH_GEN_DROP_CNT_EN
    do_reset();
    cfg_port(0, 1'b0);
    for (int k = 0; k < 300; k++) begin
      drive(0, 1, DW'(k));
      tick();
    end
    wr_en = '0;
    tick();
    @(negedge clk);
    check("drop_cnt0_sat", drop_cnt[7:0],  8'hFF);
    check("drop_cnt1",     drop_cnt[15:8], 8'h00);
    tick();
    cfg_port(0, 1'b1);
`endif

    for (int o = 0; o < N; o++) check($sformatf("sb_left_out%0d", o), sb[o].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xswitch_gen.md
Name: xswitch_gen

Overview:
Parametrised N-port crossbar packet switch; next generation of the fixed 4-port xswitch.
- Each input port has its own synchronous FIFO of {dest addr, data} beats.
- Each output port has a priority/round-robin arbiter and a one-beat output register with a ready/read handshake.
- Per-port enable and 2-bit priority come from a shared configuration write port.
- Sits under the same interface/dut_top wrapper style as the existing switch; vectors are flattened per port.

Parameters:
- N_PORTS, 4, number of input and output ports (2..16).
- DATA_W, 8, payload width per beat.
- FIFO_DEPTH, 8, entries per input FIFO (power of two, ≥4).
- AE_LVL, 2, almost-empty threshold: fifo_ae=1 when count ≤ AE_LVL.
- AF_LVL, 6, almost-full threshold: fifo_af=1 when count ≥ AF_LVL.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- data_in  in  N_PORTS*DATA_W  input beats, port p at slice p.
- addr_in  in  N_PORTS*AW (AW=clog2(N_PORTS))  destination output port.
- wr_en  in  N_PORTS  push strobe per input.
- data_rcv  out  N_PORTS  1-cycle pulse: beat accepted into FIFO.
- fifo_empty/fifo_full/fifo_ae/fifo_af  out  N_PORTS each  input FIFO flags (registered).
- data_out  out  N_PORTS*DATA_W  output beat.
- addr_out  out  N_PORTS*AW  source input port of the beat.
- data_rdy  out  N_PORTS  output register valid.
- rd_en  in  N_PORTS  consumer takes beat.
- prio_val  in  2  priority value (3 = highest).
- prio_wr  in  1  write prio_val to port port_sel.
- port_en  in  1  enable value.
- port_wr  in  1  write port_en to port port_sel (affects input and output p).
- port_sel  in  AW  config target port.

Behaviour:
- Reset (synchronous): FIFOs cleared; data_out=0, addr_out=0, data_rdy=0, data_rcv=0; fifo_empty=1, fifo_ae=1, fifo_full=0, fifo_af=0; all priorities 0; all ports enabled.
- Push: wr_en[p] with port p enabled and fifo_full[p]=0 stores {addr,data}; data_rcv[p]=1 next cycle.
  - A write while full is dropped, even if a pop happens in the same cycle.
  - A write to a disabled port is dropped; data_rcv stays 0.
- Head decode: an entry with addr ≥ N_PORTS is popped and discarded one cycle after reaching the head.
- Arbitration per output o, each cycle:
  - Candidates are enabled inputs i whose FIFO is non-empty and whose head addr=o, provided output o is enabled.
  - The highest prio[i] wins.
  - Ties go round-robin, starting after the last granted input for o. The pointer advances only on a grant.
- Grant condition: output register free (data_rdy[o]=0), or being drained this cycle (rd_en[o]&data_rdy[o]).
- On grant: pop input i, load data_out/addr_out (addr_out=i), set data_rdy[o].
- Back-to-back: one beat per cycle per output when rd_en is held high.
- Latency: push at edge t → data_rdy at edge t+2 on an idle path.
- rd_en while data_rdy=0 is ignored.
- No two outputs can grant the same input, because each head has one destination. Head-of-line blocking is accepted.
- Disabling an output mid-traffic: the held beat stays valid until read; no new grants.
- Disabling an input: queued beats are frozen, not flushed, until re-enabled.
- Config writes take effect for arbitration on the next cycle. prio_wr and port_wr in the same cycle both apply.
- Flags derive from an occupancy counter of width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: XSWITCH_GEN_DROP_CNT_EN.
- Defined: adds output port drop_cnt [N_PORTS*8], one per input. It counts dropped writes (full or disabled) and dropped out-of-range heads. Saturates at 255; cleared by reset.
- Undefined: the port and counters are absent; drops are silent.

Decomposition:
- Package xswitch_gen_pkg: prio_t (2-bit), derived width function for AW/count, beat struct {addr, data}.
- Sub-module xsw_fifo: parametrised synchronous FIFO with count and registered empty/full/ae/af flags, instantiated N_PORTS times.
- Arbiters stay in the top-level generate loop.

Test Plan:
- Single beat: in0 addr=2 data=0x5A, rd_en[2]=1 → data_rdy[2] at t+2, data_out=0x5A, addr_out=0, data_rcv[0] pulse at t+1.
- Contention: in1 and in3 both to out0, prio equal → alternating grants 1,3,1,3; set prio[3]=3 → only in3 served until its FIFO is empty.
- Fill in2 with 8 beats to out1, rd_en[1]=0 → full=1 after 8 pushes, af from 6th push; 9th write dropped with no data_rcv; drain restores empty=1, ae=1.
- port_wr port_sel=1 en=0, then write in1 → dropped; traffic to out1 stalls, held beat still readable.
- Reset asserted mid-stream with 3 beats queued → next cycle all FIFOs empty, data_rdy=0, priorities 0.
- With XSWITCH_GEN_DROP_CNT_EN: 300 writes to disabled in0 → drop_cnt[0]=255.
